up_down_count: RTL and testbench



---
 rtl/up_down_count_pkg.sv | 15 +
 rtl/up_down_count_next.sv | 27 ++
 rtl/up_down_count.sv | 54 +++++
 tb/tb_up_down_count.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/up_down_count_pkg.sv
// Shared constants for the up/down counter: default width, mode encoding
// and the all-ones preset value.
package up_down_count_pkg;

   localparam int WIDTH_DEFAULT = 5;

   localparam logic MODE_DOWN = 1'b0;
   localparam logic MODE_UP   = 1'b1;

   // Callers truncate the result to their own width; legal widths are 2..32.
   function automatic logic [31:0] preset_value(input int width);
      return 32'hFFFF_FFFF >> (32 - width);
   endfunction

endpackage

// File: rtl/up_down_count_next.sv
// Next-count logic: preset to all-ones, otherwise step up or down modulo 2^WIDTH.
module up_down_count_next
   import up_down_count_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] count,
   input  logic             mode,
   input  logic             preset,
   output logic [WIDTH-1:0] count_next
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ONES = WIDTH'(preset_value(WIDTH));

   always_comb begin
      count_next = count;
      if (preset) begin
         count_next = ONES;
      end else if (mode == MODE_UP) begin
         count_next = count + ONE;
      end else begin
         count_next = count - ONE;
      end
   end

endmodule

// File: rtl/up_down_count.sv
// Up/down counter register with async active-low reset. Define
// UP_DOWN_COUNT_TC_EN to add the wrap-ahead terminal-count output tc.
module up_down_count
   import up_down_count_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             preset,
   input  logic             mode,
   output logic [WIDTH-1:0] count
`ifdef UP_DOWN_COUNT_TC_EN
   ,
   output logic             tc
`endif
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_next;

   up_down_count_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .count      (count_q),
      .mode       (mode),
      .preset     (preset),
      .count_next (count_next)
   );

   always_comb begin
      count_d = count_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

`ifdef UP_DOWN_COUNT_TC_EN
   localparam logic [WIDTH-1:0] ONES = WIDTH'(preset_value(WIDTH));

   // Gated by reset so a held-in-reset counter never reports an imminent wrap.
   assign tc = reset & (((mode == MODE_UP)   && (count_q == ONES)) ||
                        ((mode == MODE_DOWN) && (count_q == '0)));
`endif

endmodule

// File: tb/tb_up_down_count.sv
// Self-checking bench for up_down_count: directed scenarios plus randomized
// traffic against a modular-arithmetic reference model.
module tb_up_down_count;

   localparam int WIDTH = 5;
   localparam int MODV  = 1 << WIDTH;
   localparam int MAXV  = MODV - 1;

   logic             clk;
   logic             reset;
   logic             preset;
   logic             mode;
   logic [WIDTH-1:0] count;
`ifdef UP_DOWN_COUNT_TC_EN
   logic             tc;
`endif

   int checks;
   int failures;
   int model;

   up_down_count #(
      .WIDTH (WIDTH)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .preset (preset),
      .mode   (mode),
      .count  (count)
`ifdef UP_DOWN_COUNT_TC_EN
      ,
      .tc     (tc)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (reset) begin
         assert (!$isunknown({mode, preset}))
            else $error("protocol: X on mode/preset while reset high");
      end
   end

   function automatic int model_next(input int cur, input logic p, input logic m);
      if (p) return MAXV;
      if (m) return (cur + 1) % MODV;
      return (cur + MODV - 1) % MODV;
   endfunction

   // Apply inputs (caller already set them), advance one edge, compare.
   task automatic step_check(input string name);
      int exp_v;
      exp_v = reset ? model_next(model, preset, mode) : 0;
      @(posedge clk);
      #1;
      checks++;
      if (count !== exp_v[WIDTH-1:0]) begin
         failures++;
         $display("FAIL %s: count=%0d expected=%0d", name, count, exp_v);
      end
      model = exp_v;
   endtask

   task automatic reset_pulse(input string name);
      reset = 1'b0;
      #1;
      checks++;
      if (count !== '0) begin
         failures++;
         $display("FAIL %s: count=%0d expected=0 during async reset", name, count);
      end
      #1;
      reset = 1'b1;
      model = 0;
   endtask

   task automatic test_reset();
      preset = 1'b0;
      mode   = 1'b1;
      #2;
      reset  = 1'b0;
      #1;
      checks++;
      if (count !== '0) begin
         failures++;
         $display("FAIL reset_immediate: count=%0d expected=0", count);
      end
      model = 0;
      for (int i = 0; i < 3; i++) step_check("reset_held");
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step_check("count_up_after_reset");
      checks++;
      if (count !== WIDTH'(3)) begin
         failures++;
         $display("FAIL up_after_reset_value: count=%0d expected=3", count);
      end
   endtask

   task automatic test_preset_down();
      preset = 1'b1;
      mode   = 1'b0;
      step_check("preset_load");
      checks++;
      if (count !== WIDTH'(31)) begin
         failures++;
         $display("FAIL preset_value: count=%0d expected=31", count);
      end
      preset = 1'b0;
      for (int i = 0; i < 4; i++) step_check("count_down");
      checks++;
      if (count !== WIDTH'(27)) begin
         failures++;
         $display("FAIL down_value: count=%0d expected=27", count);
      end
   endtask

   task automatic test_up_wrap();
      mode = 1'b1;
      for (int i = 0; i < 6; i++) step_check("up_wrap");
      checks++;
      if (count !== WIDTH'(1)) begin
         failures++;
         $display("FAIL up_wrap_end: count=%0d expected=1", count);
      end
   endtask

   task automatic test_down_wrap();
      reset_pulse("down_wrap_reset");
      mode = 1'b0;
      step_check("down_wrap");
      checks++;
      if (count !== WIDTH'(31)) begin
         failures++;
         $display("FAIL down_wrap_from_zero: count=%0d expected=31", count);
      end
      step_check("down_after_wrap");
   endtask

   task automatic test_preset_priority();
      preset = 1'b1;
      mode   = 1'b1;
      step_check("preset_beats_up_1");
      step_check("preset_beats_up_2");
      checks++;
      if (count !== WIDTH'(31)) begin
         failures++;
         $display("FAIL preset_hold: count=%0d expected=31", count);
      end
      reset_pulse("preset_reset_pulse");
      preset = 1'b0;
      step_check("after_pulse_up");
   endtask

`ifdef UP_DOWN_COUNT_TC_EN
   task automatic tc_check(input string name);
      logic exp_tc;
      exp_tc = reset && ((mode && model == MAXV) || (!mode && model == 0));
      checks++;
      if (tc !== exp_tc) begin
         failures++;
         $display("FAIL %s: tc=%b expected=%b (count=%0d mode=%b)", name, tc, exp_tc, count, mode);
      end
   endtask

   task automatic test_tc();
      preset = 1'b1;
      mode   = 1'b1;
      step_check("tc_setup_preset");
      preset = 1'b0;
      #1;
      tc_check("tc_ones_up");
      mode = 1'b0;
      #1;
      tc_check("tc_ones_down");
      reset_pulse("tc_setup_zero");
      mode = 1'b0;
      #1;
      tc_check("tc_zero_down");
      mode = 1'b1;
      #1;
      tc_check("tc_zero_up");
      mode  = 1'b0;
      reset = 1'b0;
      model = 0;
      #1;
      tc_check("tc_in_reset");
      reset = 1'b1;
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         preset = ($urandom_range(0, 7) == 0);
         mode   = $urandom_range(0, 1);
         step_check("random");
`ifdef UP_DOWN_COUNT_TC_EN
         tc_check("random_tc");
`endif
         if ($urandom_range(0, 31) == 0) reset_pulse("random_reset");
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      model    = 0;
      reset    = 1'b1;
      preset   = 1'b0;
      mode     = 1'b1;
      test_reset();
      test_preset_down();
      test_up_wrap();
      test_down_wrap();
      test_preset_priority();
`ifdef UP_DOWN_COUNT_TC_EN
      test_tc();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
